ble_frac_k: RTL and testbench
=============================

Name: ble_frac_k

Overview:
- Parametrised successor to the fixed 6-input basic logic element in the clb/fle hierarchy.
- Contains a K-input LUT that can fracture into two (K-1)-input LUTs, with one flip-flop and one output-select mux per output.
- Configuration chain runs on the user clock, gated by a shift enable, and has a completion flag.
- Chained with sibling BLEs through ccff_head/ccff_tail inside the fle tile.

Parameters:
- K, 6, LUT input count; legal range 3..8.
- CFG_BITS, 2**K+5, derived localparam (not overridable); configuration chain length.

Ports:
- clk  input  1  single clock for configuration shift and user flip-flops.
- reset  input  1  asynchronous, active-high reset.
- cfg_en  input  1  configuration shift enable.
- ccff_head  input  1  configuration serial in.
- ccff_tail  output  1  configuration serial out, MSB of the chain.
- cfg_done  output  1  high once CFG_BITS bits have been shifted.
- ble_in  input  K  LUT inputs; ble_in[0] is the LSB of the LUT index.
- ce  input  1  flip-flop clock enable.
- ff_load  input  1  synchronous load of the flip-flops with their configured init values.
- ble_out  output  2  BLE outputs [0] and [1].

Behaviour:
- Decided: one clock (clk); reset is asynchronous and active-high (reset).
- Reset asserted clears all of the following: cfg_sr, bit counter, ff0_q, ff1_q. Consequently ccff_tail=0, cfg_done=0, ble_out=2'b00.
- Chain shift: on a clk edge with cfg_en=1, cfg_sr <= {cfg_sr[CFG_BITS-2:0], ccff_head}. ccff_tail = cfg_sr[CFG_BITS-1] (registered, no combinational path). A bit entered at edge t appears on ccff_tail after edge t+CFG_BITS-1. With cfg_en=0, cfg_sr holds.
- Chain field map (MSB shifted in first):
  - cfg_sr[2**K-1:0] = lut mask
  - [2**K] = frac
  - [2**K+1] = osel0
  - [2**K+2] = osel1
  - [2**K+3] = ff0_init
  - [2**K+4] = ff1_init
- Bit counter (width clog2(CFG_BITS+1)): increments on each cfg_en edge and saturates at CFG_BITS. cfg_done = (count==CFG_BITS). Only reset clears the counter. Re-shifting after cfg_done is allowed and cfg_done stays 1.
- LUT evaluation (combinational):
  - frac=0: lutA = mask[ble_in]; lutB = lutA.
  - frac=1: lutA = mask[{1'b0, ble_in[K-2:0]}]; lutB = mask[{1'b1, ble_in[K-2:0]}]; ble_in[K-1] is ignored.
- Flip-flops, per clk edge, priority high to low:
  1. cfg_en=1 → hold.
  2. ff_load=1 → ff0_q <= ff0_init, ff1_q <= ff1_init.
  3. ce=1 → ff0_q <= lutA, ff1_q <= lutB.
  4. Otherwise → hold.
- Outputs:
  - raw0 = osel0 ? ff0_q : lutA; raw1 = osel1 ? ff1_q : lutB.
  - ble_out = (cfg_done & ~cfg_en) ? {raw1, raw0} : 2'b00.
  - Forcing to zero during configuration prevents partial-mask glitches from reaching routing.
- Latency: combinational path ble_in→ble_out when osel=0; one cycle when osel=1 and ce=1.
- Reset mid-configuration: all state is cleared immediately and the full CFG_BITS must be reshifted. A reset between edges aborts the shift with no partial counter value retained.
- Simultaneous cfg_en and ff_load/ce: cfg_en wins, and the flip-flops hold.

Test Plan:
1. Apply reset, then release; idle 5 cycles → ble_out=00, ccff_tail=0, cfg_done=0. Apply 68 cfg_en pulses → cfg_done=0; after the 69th → cfg_done=1.
2. K=6: shift mask=64'h8000_0000_0000_0000, frac=0, osel0=osel1=0, inits=0. Then ble_in=6'h3F → ble_out=11 in the same cycle; ble_in=6'h3E → ble_out=00.
3. Same mask with osel0=1, ce=1: ble_in=6'h3F sampled at edge n → ble_out[0]=1 after edge n, ble_out[1]=1 combinationally. Drop ce=0 and set ble_in=0 → ble_out[0] stays 1.
4. Fracture: mask upper 32=32'hFFFF0000, lower 32=32'hAAAAAAAA, frac=1. ble_in=6'b010001 → ble_out=11; ble_in=6'b000001 → ble_out=01; ble_in=6'b110000 → ble_out=10 (bit 5 ignored).
5. Chain pass-through: after configuration, shift 1,0,1,1 with cfg_en=1 → the original MSB config bits emerge on ccff_tail in order. ble_out=00 while cfg_en=1, and ble_out returns to the LUT value the cycle cfg_en drops.
6. Set ff0_init=1, ff1_init=0, osel=11, then pulse ff_load with ce=1 → ble_out=01 next cycle. Assert reset at shift cycle 30 of a reconfiguration → ble_out=00, cfg_done=0 immediately; a full 69-bit reshift restores cfg_done=1.

Source files
------------

// File: rtl/ble_frac_k.sv
// Fracturable K-input basic logic element: a K-LUT (or two (K-1)-LUTs), two
// output flip-flops and output-select muxes, configured by a serial chain on clk.
module ble_frac_k #(
  parameter int K = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_en,
  input  logic         ccff_head,
  output logic         ccff_tail,
  output logic         cfg_done,
  input  logic [K-1:0] ble_in,
  input  logic         ce,
  input  logic         ff_load,
  output logic [1:0]   ble_out
);

  localparam int LUT_SIZE  = 1 << K;
  localparam int CFG_BITS  = LUT_SIZE + 5;
  localparam int CNT_W     = $clog2(CFG_BITS + 1);
  localparam int FRAC_IDX  = LUT_SIZE;
  localparam int OSEL0_IDX = LUT_SIZE + 1;
  localparam int OSEL1_IDX = LUT_SIZE + 2;
  localparam int INIT0_IDX = LUT_SIZE + 3;
  localparam int INIT1_IDX = LUT_SIZE + 4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  if (K < 3 || K > 8) begin : g_k_range
    $error("ble_frac_k: K must be in 3..8");
  end

  logic [CFG_BITS-1:0] cfg_sr_q, cfg_sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ff0_q, ff0_d;
  logic                ff1_q, ff1_d;

  logic [LUT_SIZE-1:0] mask;
  logic                frac, osel0, osel1, init0, init1;
  logic [K-1:0]        idx_a, idx_b;
  logic                lut_a, lut_b;
  logic                raw0, raw1;

  assign mask  = cfg_sr_q[LUT_SIZE-1:0];
  assign frac  = cfg_sr_q[FRAC_IDX];
  assign osel0 = cfg_sr_q[OSEL0_IDX];
  assign osel1 = cfg_sr_q[OSEL1_IDX];
  assign init0 = cfg_sr_q[INIT0_IDX];
  assign init1 = cfg_sr_q[INIT1_IDX];

  // Configuration chain and saturating bit counter
  always_comb begin
    cfg_sr_d = cfg_sr_q;
    cnt_d    = cnt_q;
    if (cfg_en) begin
      cfg_sr_d = {cfg_sr_q[CFG_BITS-2:0], ccff_head};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Fractured mode splits the mask in halves selected by the top index bit
  always_comb begin
    idx_a = ble_in;
    idx_b = ble_in;
    if (frac) begin
      idx_a = {1'b0, ble_in[K-2:0]};
      idx_b = {1'b1, ble_in[K-2:0]};
    end
    lut_a = mask[idx_a];
    lut_b = frac ? mask[idx_b] : lut_a;
  end

  always_comb begin
    ff0_d = ff0_q;
    ff1_d = ff1_q;
    if (!cfg_en) begin
      if (ff_load) begin
        ff0_d = init0;
        ff1_d = init1;
      end else if (ce) begin
        ff0_d = lut_a;
        ff1_d = lut_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_sr_q <= '0;
      cnt_q    <= '0;
      ff0_q    <= 1'b0;
      ff1_q    <= 1'b0;
    end else begin
      cfg_sr_q <= cfg_sr_d;
      cnt_q    <= cnt_d;
      ff0_q    <= ff0_d;
      ff1_q    <= ff1_d;
    end
  end

  // Outputs stay low until a full configuration is present and shifting has stopped
  always_comb begin
    raw0    = osel0 ? ff0_q : lut_a;
    raw1    = osel1 ? ff1_q : lut_b;
    ble_out = (cfg_done && !cfg_en) ? {raw1, raw0} : 2'b00;
  end

  assign ccff_tail = cfg_sr_q[CFG_BITS-1];
  assign cfg_done  = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_ble_frac_k.sv
// Directed bench for ble_frac_k (K=6): a bit-history model checked every cycle,
// plus literal expectations from hand-worked vectors.
module tb_ble_frac_k;

  localparam int K    = 6;
  localparam int NCFG = 69;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_en = 1'b0;
  logic       ccff_head = 1'b0;
  logic       ccff_tail;
  logic       cfg_done;
  logic [5:0] ble_in = '0;
  logic       ce = 1'b0;
  logic       ff_load = 1'b0;
  logic [1:0] ble_out;

  int passed = 0;
  int total  = 0;

  ble_frac_k #(.K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_en    (cfg_en),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .cfg_done  (cfg_done),
    .ble_in    (ble_in),
    .ce        (ce),
    .ff_load   (ff_load),
    .ble_out   (ble_out)
  );

  always #5 clk = ~clk;

  // Model: every bit shifted since reset, newest last; chain position i holds
  // the bit shifted i edges before the newest one.
  bit hist[$];
  bit m_ff0, m_ff1;

  function automatic bit cfg_bit(int i);
    int n = hist.size();
    if (n - 1 - i >= 0) return hist[n - 1 - i];
    return 1'b0;
  endfunction

  function automatic void model_lut(input logic [5:0] bi, output bit a, output bit b);
    if (cfg_bit(64)) begin
      a = cfg_bit(bi % 32);
      b = cfg_bit(32 + (bi % 32));
    end else begin
      a = cfg_bit(bi);
      b = a;
    end
  endfunction

  function automatic logic [1:0] model_out();
    bit a, b, r0, r1;
    model_lut(ble_in, a, b);
    r0 = cfg_bit(65) ? m_ff0 : a;
    r1 = cfg_bit(66) ? m_ff1 : b;
    if (hist.size() >= NCFG && !cfg_en) return {r1, r0};
    return 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit a, b;
    if (reset) begin
      hist.delete();
      m_ff0 = 1'b0;
      m_ff1 = 1'b0;
    end else begin
      model_lut(ble_in, a, b);
      if (cfg_en) begin
        hist.push_back(ccff_head);
      end else if (ff_load) begin
        m_ff0 = cfg_bit(67);
        m_ff1 = cfg_bit(68);
      end else if (ce) begin
        m_ff0 = a;
        m_ff1 = b;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] exp_out;
    logic       exp_tail, exp_done;
    exp_out  = model_out();
    exp_tail = cfg_bit(68);
    exp_done = (hist.size() >= NCFG);
    total++;
    if (ble_out === exp_out && ccff_tail === exp_tail && cfg_done === exp_done) passed++;
    else $display("FAIL model_cmp t=%0t: ble_out=%b tail=%b done=%b, expected %b %b %b",
                  $time, ble_out, ccff_tail, cfg_done, exp_out, exp_tail, exp_done);
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [68:0] mk(input logic [63:0] m, input logic fr, input logic o0,
                                     input logic o1, input logic i0, input logic i1);
    return {i1, i0, o1, o0, fr, m};
  endfunction

  task automatic shift_word(input logic [68:0] w);
    for (int i = NCFG - 1; i >= 0; i--) begin
      cfg_en    = 1'b1;
      ccff_head = w[i];
      step();
    end
    cfg_en    = 1'b0;
    ccff_head = 1'b0;
  endtask

  logic [68:0] w4, w6;
  logic [3:0]  pat;
  logic [3:0]  exp_tail4;

  initial begin
    // 1: reset, idle, done boundary
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    chk("idle_out", ble_out, 2'b00);
    chk("idle_tail_done", {ccff_tail, cfg_done}, 2'b00);
    cfg_en = 1'b1;
    repeat (68) step();
    chk("done_after_68", {1'b0, cfg_done}, 2'b00);
    chk("out_zero_while_shift", ble_out, 2'b00);
    step();
    cfg_en = 1'b0;
    #1;
    chk("done_after_69", {1'b0, cfg_done}, 2'b01);

    // 2: single-minterm AND, combinational outputs
    shift_word(mk(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    ble_in = 6'h3F; #1;
    chk("and_3f", ble_out, 2'b11);
    ble_in = 6'h3E; #1;
    chk("and_3e", ble_out, 2'b00);

    // 3: registered output 0
    shift_word(mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    ble_in = 6'h3F; ce = 1'b1;
    step();
    chk("reg_after_edge", ble_out, 2'b11);
    ce = 1'b0; ble_in = 6'h00; #1;
    chk("reg_hold", ble_out, 2'b01);
    step();
    chk("reg_hold_next", ble_out, 2'b01);

    // 4: fractured mode
    w4 = mk({32'hFFFF0000, 32'hAAAAAAAA}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(w4);
    ble_in = 6'b010001; #1;
    chk("frac_010001", ble_out, 2'b11);
    ble_in = 6'b000001; #1;
    chk("frac_000001", ble_out, 2'b01);
    ble_in = 6'b110000; #1;
    chk("frac_110000", ble_out, 2'b10);
    step();

    // 5: chain pass-through, outputs forced low while shifting
    chk("tail_before", {1'b0, ccff_tail}, {1'b0, w4[68]});
    pat = 4'b1011;
    exp_tail4 = {w4[67], w4[66], w4[65], w4[64]};
    for (int i = 3; i >= 0; i--) begin
      cfg_en = 1'b1; ccff_head = pat[i]; #1;
      chk("out_low_shift", ble_out, 2'b00);
      step();
      chk("tail_pass", {1'b0, ccff_tail}, {1'b0, exp_tail4[i]});
    end
    cfg_en = 1'b0; ccff_head = 1'b0; #1;
    chk("out_after_pass", ble_out, 2'b11);
    step();

    // 6: ff_load beats ce; reset during reconfiguration
    w6 = mk(64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    shift_word(w6);
    ff_load = 1'b1; ce = 1'b1;
    step();
    ff_load = 1'b0; ce = 1'b0; #1;
    chk("ff_load", ble_out, 2'b01);
    cfg_en = 1'b1; ce = 1'b1; ble_in = 6'h3F;
    repeat (30) step();
    reset = 1'b1; #1;
    chk("rst_out", ble_out, 2'b00);
    chk("rst_tail_done", {ccff_tail, cfg_done}, 2'b00);
    cfg_en = 1'b0; ce = 1'b0;
    #1 reset = 1'b0;
    step();
    shift_word(w6);
    chk("reshift_done", {1'b0, cfg_done}, 2'b01);
    chk("reshift_ff_cleared", ble_out, 2'b00);
    ff_load = 1'b1;
    step();
    ff_load = 1'b0; #1;
    chk("reload", ble_out, 2'b01);
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
